fp_div_seq: RTL and testbench

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_div_seq.sv | 164 ++++++++++++++++
 tb/tb_fp_div_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 binary32 divider, restoring radix-2, truncating.
// Fixed 28-edge latency from accept to done, specials included.
module fp_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic [3:0]  flags
);

    typedef enum logic [2:0] {
        IDLE, UNPACK, DIVIDE, NORM, PACK, DONE
    } state_t;

    state_t state, nxt;

    logic [31:0]       opa, opb;
    logic [4:0]        cnt;
    logic [25:0]       rem;
    logic [24:0]       q;
    logic [23:0]       mb;
    logic signed [9:0] ex;
    logic              sgn;
    logic              sp;
    logic [31:0]       sp_res;
    logic [3:0]        sp_flg;

    function automatic logic [26:0] step(
        input logic [25:0] r,
        input logic [23:0] d
    );
        logic        ge;
        logic [25:0] t;
        ge = r >= {2'b00, d};
        t  = ge ? r - {2'b00, d} : r;
        return {ge, t[24:0], 1'b0};
    endfunction

    logic [7:0]  ea, eb;
    logic [23:0] ma_u, mb_u;
    logic        za, zb, ia, ib, na, nb, s_u;
    logic [26:0] st0, stn;

    always_comb begin
        ea   = opa[30:23];
        eb   = opb[30:23];
        za   = ea == 8'd0;
        zb   = eb == 8'd0;
        ia   = ea == 8'hFF && opa[22:0] == 23'd0;
        ib   = eb == 8'hFF && opb[22:0] == 23'd0;
        na   = ea == 8'hFF && opa[22:0] != 23'd0;
        nb   = eb == 8'hFF && opb[22:0] != 23'd0;
        s_u  = opa[31] ^ opb[31];
        ma_u = za ? 24'd0 : {1'b1, opa[22:0]};
        mb_u = zb ? 24'd0 : {1'b1, opb[22:0]};
        st0  = step({2'b00, ma_u}, mb_u);
        stn  = step(rem, mb);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = UNPACK;
            UNPACK:  nxt = DIVIDE;
            DIVIDE:  if (cnt == 5'd23) nxt = NORM;
            NORM:    nxt = PACK;
            PACK:    nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign busy = state != IDLE && state != DONE;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa    <= '0;
            opb    <= '0;
            cnt    <= '0;
            rem    <= '0;
            q      <= '0;
            mb     <= '0;
            ex     <= '0;
            sgn    <= 1'b0;
            sp     <= 1'b0;
            sp_res <= '0;
            sp_flg <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa <= a;
                        opb <= b;
                    end
                end
                UNPACK: begin
                    // first quotient bit is produced here, 24 more in DIVIDE
                    rem <= st0[25:0];
                    q   <= {24'd0, st0[26]};
                    mb  <= mb_u;
                    cnt <= '0;
                    sgn <= s_u;
                    ex  <= $signed({2'b00, ea}) - $signed({2'b00, eb})
                           + 10'sd127;
                    sp     <= 1'b1;
                    sp_flg <= 4'b0000;
                    sp_res <= {s_u, 31'd0};
                    if (na || nb || (za && zb) || (ia && ib)) begin
                        sp_res <= 32'h7FC00000;
                        sp_flg <= 4'b1000;
                    end else if (ia) begin
                        sp_res <= {s_u, 8'hFF, 23'd0};
                    end else if (zb) begin
                        sp_res <= {s_u, 8'hFF, 23'd0};
                        sp_flg <= 4'b0100;
                    end else if (!(ib || za)) begin
                        sp <= 1'b0;
                    end
                end
                DIVIDE: begin
                    rem <= stn[25:0];
                    q   <= {q[23:0], stn[26]};
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    if (!q[24]) begin
                        q  <= {q[23:0], 1'b0};
                        ex <= ex - 10'sd1;
                    end
                end
                PACK: begin
                    if (sp) begin
                        result <= sp_res;
                        flags  <= sp_flg;
                    end else if (ex >= 10'sd255) begin
                        result <= {sgn, 8'hFF, 23'd0};
                        flags  <= 4'b0010;
                    end else if (ex <= 10'sd0) begin
                        result <= {sgn, 31'd0};
                        flags  <= 4'b0001;
                    end else begin
                        result <= {sgn, ex[7:0], q[23:1]};
                        flags  <= 4'b0000;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Randomized + directed bench for fp_div_seq against a
// plain-arithmetic binary32 truncating division model.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic [3:0]  flags;

    int npass = 0;
    int ntot  = 0;

    fp_div_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] got,
                       input logic [35:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [35:0] ref_div(input logic [31:0] x,
                                            input logic [31:0] y);
        int     xe, ye, e;
        logic   s, zx, zy, ix, iy, nx, ny;
        longint mx, my, qq, frac;
        xe = int'(x[30:23]);
        ye = int'(y[30:23]);
        zx = xe == 0;
        zy = ye == 0;
        ix = xe == 255 && x[22:0] == 0;
        iy = ye == 255 && y[22:0] == 0;
        nx = xe == 255 && x[22:0] != 0;
        ny = ye == 255 && y[22:0] != 0;
        s  = x[31] ^ y[31];
        if (nx || ny || (zx && zy) || (ix && iy))
            return {4'b1000, 32'h7FC00000};
        if (ix) return {4'b0000, s, 8'hFF, 23'd0};
        if (zy) return {4'b0100, s, 8'hFF, 23'd0};
        if (iy || zx) return {4'b0000, s, 31'd0};
        mx = longint'(x[22:0]) + (64'd1 << 23);
        my = longint'(y[22:0]) + (64'd1 << 23);
        qq = (mx << 24) / my;
        e  = xe - ye + 127;
        if (qq < (64'd1 << 24)) begin
            e    = e - 1;
            frac = qq & 64'h7FFFFF;
        end else begin
            frac = (qq >> 1) & 64'h7FFFFF;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0001, s, 31'd0};
        return {4'b0000, s, e[7:0], frac[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 11);
        if (k == 0)      v[30:23] = 8'd0;
        else if (k == 1) v[30:0] = {8'hFF, 23'd0};
        else if (k == 2) v[30:23] = 8'hFF;
        else if (k == 3) v[30:23] = 8'($urandom_range(1, 20));
        else if (k == 4) v[30:23] = 8'($urandom_range(235, 254));
        else             v[30:23] = 8'($urandom_range(64, 190));
        return v;
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input string tag);
        logic [35:0] exp;
        logic [31:0] prev;
        int          lat;
        bit          moved;
        exp   = ref_div(x, y);
        prev  = result;
        moved = 0;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        chk({tag, "_busy"}, 36'(busy), 36'd1);
        while (!done && lat < 60) begin
            if (result !== prev) moved = 1;
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, 36'(lat), 36'd28);
        chk({tag, "_res"}, {flags, result}, exp);
        chk({tag, "_hold"}, 36'(moved), 36'd0);
        chk({tag, "_bsy_dn"}, 36'(busy), 36'd0);
        @(posedge clk);
        #1 chk({tag, "_pulse"}, 36'(done), 36'd0);
    endtask

    initial begin : main
        int lat;
        logic [35:0] e1;
        #1 chk("rst_out", {flags, result}, 36'd0);
        chk("rst_hs", 36'({busy, done}), 36'd0);
        #12 @(negedge clk) reset = 1'b1;

        run_op(32'h40C00000, 32'h40000000, "six_two");
        run_op(32'h3F800000, 32'h40400000, "one_three");
        run_op(32'h3F800000, 32'h00000000, "div0");
        run_op(32'h80000000, 32'h00000000, "zz");
        run_op(32'h7F000000, 32'h00800000, "ovf");
        run_op(32'h00800000, 32'h7F000000, "unf");
        run_op(32'h7F800000, 32'h7F800000, "ii");
        run_op(32'hFF800000, 32'h3F800000, "i_f");
        run_op(32'h3F800000, 32'hFF800000, "f_i");
        run_op(32'h7FC00001, 32'h3F800000, "nan");
        run_op(32'h00000001, 32'h40000000, "den");
        run_op(32'h7F800000, 32'h00000000, "i_z");

        // start pulses while busy must be ignored
        e1 = ref_div(32'h41200000, 32'h40A00000);
        @(negedge clk);
        a = 32'h41200000;
        b = 32'h40A00000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            if (lat == 5 || lat == 10) begin
                @(negedge clk);
                a = 32'h3F800000;
                b = 32'h40400000;
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            lat++;
        end
        chk("busy_lat", 36'(lat), 36'd28);
        chk("busy_res", {flags, result}, e1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 chk("done_start", 36'({busy, done}), 36'd0);
        start = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done) lat++;
        end
        chk("no_extra", 36'(lat), 36'd0);

        // reset mid-divide aborts the operation
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("arst_out", {flags, result}, 36'd0);
        chk("arst_hs", 36'({busy, done}), 36'd0);
        @(negedge clk);
        reset = 1'b1;
        lat = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1 if (done || busy) lat++;
        end
        chk("arst_quiet", 36'(lat), 36'd0);
        run_op(32'h40C00000, 32'h40000000, "post_rst");

        for (int i = 0; i < 40; i++)
            run_op(rnd_op(), rnd_op(), $sformatf("rnd%0d", i));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
